usb_dbg_event_monitor: RTL
==========================

Name: usb_dbg_event_monitor

Overview:
- Wishbone-side consumer of the USB core's debug strobes: the stretched ACK-timeout, ACK-received and bad-packet pulses, plus the 4-bit transaction-state bus.
- Synchronises these inputs into wb_clk_i and counts events in saturating counters.
- Detects a transaction FSM stuck in a non-idle state.
- Exposes counters and status as Wishbone registers, with a level interrupt for firmware.

Parameters:
- CNT_W, 16: width of each event counter; must be 1..32.
- STUCK_LIMIT_DEF, 32'd60000: reset value of STUCK_LIMIT, in wb_clk_i cycles.
- SYNC_STAGES, 2: synchroniser depth for all USB-domain inputs; must be ≥2.

Ports:
- Clocking and reset: the block has one clock, wb_clk_i, and an asynchronous, active-high reset, wb_rst_i.
- wb_clk_i  in  1  Wishbone clock; all logic runs on it.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  5  byte address; bits [4:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- ack_tout_stretched_i  in  1  stretched ACK-timeout pulse (USB domain).
- ack_received_stretched_i  in  1  stretched ACK-received pulse (USB domain).
- ack_bad_packet_stretched_i  in  1  stretched bad-packet pulse (USB domain).
- transact_state_i  in  4  transaction FSM state (USB domain); 0 = idle.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, all counters 0, all sync flops 0, CTRL.EN=1, CTRL.IE=0, STUCK flag 0, STUCK_LIMIT=STUCK_LIMIT_DEF, stuck timer 0.
- Registers (word index = wb_adr_i[4:2]):
  - 0 CTRL: [0] EN (R/W), [1] CLR (write-1 pulse, reads 0), [2] IE (R/W).
  - 1 ACK_TOUT_CNT: read-only.
  - 2 ACK_RX_CNT: read-only.
  - 3 BAD_PKT_CNT: read-only.
  - 4 STATUS: [3:0] filtered state (RO), [4] STUCK (RO, W1C), [5] SAT (RO).
  - 5 STUCK_LIMIT: R/W, 32 bits.
  - Indices 6-7: read 0, writes ignored.
  - Counters are zero-extended to 32 bits.
- Wishbone handshake:
  - wb_ack_o=1 for exactly one cycle, in the cycle after cyc&stb is sampled with wb_ack_o=0.
  - The cycle following an ack never acks, so back-to-back access yields an ack every second cycle.
  - Write data takes effect on the ack cycle edge.
  - wb_dat_o is registered with the ack and held until the next ack.
- Event counting:
  - Each strobe passes through SYNC_STAGES flops, then a rising-edge detector (registered previous value).
  - Each edge while EN=1 increments the corresponding counter by 1, saturating at all-ones (no wrap).
  - Latency from input rise to counter update is SYNC_STAGES+1 cycles.
  - A level held high counts once.
  - EN=0 drops edges; they are not queued.
- SAT: set while any counter equals all-ones.
- CLR:
  - Zeroes all three counters, the STUCK flag and the stuck timer on the write's ack edge.
  - CLR takes priority over a same-cycle increment: the result is 0 and the edge is lost.
- State filter and stuck detection:
  - transact_state_i is synchronised bitwise.
  - The filtered state updates only when two consecutive synchronised samples are equal.
  - The stuck timer resets to 0 when the filtered state changes or equals 0; otherwise it increments and saturates at 32'hFFFFFFFF.
  - When the timer == STUCK_LIMIT and STUCK_LIMIT != 0, STUCK is set (sticky). STUCK_LIMIT=0 disables detection.
  - If a W1C write to STUCK coincides with a set condition, the set wins.
- irq_o: registered IE & STUCK, one cycle after either changes.
- Reset asserted mid-transfer: all state returns to reset values immediately; a pending ack is dropped.

Test Plan:
- Reset, then read all six registers → CTRL=0x1, STUCK_LIMIT=60000, all others 0; each access acks after exactly one cycle.
- 5 pulses on ack_received_stretched_i, each 4 cycles high with 4 low → ACK_RX_CNT=5, other counters 0; 3rd pulse visible on the counter 3 cycles after its rise.
- With CNT_W=4, 20 bad-packet pulses → BAD_PKT_CNT=15, STATUS[5]=1; write CTRL=0x3 → counters 0, SAT=0, EN still 1.
- STUCK_LIMIT=100, IE=1, hold transact_state_i=4'h3 → STUCK and irq_o=1 about 100 cycles after filtered state settles; toggling state every 50 cycles never sets STUCK.
- Write STATUS=0x10 while state remains stuck and timer==limit in the same cycle → STUCK stays 1; move state to 0 then W1C → STUCK=0, irq_o=0 next cycle.
- CTRL.EN=0, 3 ACK-timeout pulses → ACK_TOUT_CNT=0; assert wb_rst_i during a pending read → wb_ack_o=0 and all registers at reset values.

Source files
------------

// File: rtl/usb_dbg_event_monitor.sv
// usb_dbg_event_monitor
//   Wishbone-side consumer of the USB core's debug strobes. The stretched
//   ACK-timeout, ACK-received and bad-packet pulses are synchronised into
//   wb_clk_i, and their rising edges are counted in saturating counters.
//   The 4-bit transaction state is synchronised and filtered, and then
//   watched for an FSM stuck in a non-idle state. Counters and status are
//   exposed as Wishbone registers, with a level interrupt on STUCK.
//
// Ports
//   wb_clk_i, wb_rst_i         clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i,        Wishbone slave: the byte address bits [4:2]
//   wb_we_i, wb_adr_i,         select one of eight word registers
//   wb_dat_i, wb_dat_o,
//   wb_ack_o
//   ack_tout_stretched_i       USB-domain event strobes (asynchronous)
//   ack_received_stretched_i
//   ack_bad_packet_stretched_i
//   transact_state_i           USB-domain transaction state, 0 = idle
//   irq_o                      registered IE & STUCK
//
// Register map (word index)
//   0 CTRL        [0] EN, [1] CLR (write-1 pulse, reads 0), [2] IE
//   1 ACK_TOUT_CNT, 2 ACK_RX_CNT, 3 BAD_PKT_CNT (read-only, zero-extended)
//   4 STATUS      [3:0] filtered state, [4] STUCK (W1C), [5] SAT
//   5 STUCK_LIMIT 32-bit R/W, 0 disables stuck detection
//   6-7           read 0, writes ignored
//
// Handshake: a request is accepted when cyc & stb are high while wb_ack_o is
// low. wb_ack_o is then high for exactly one cycle. Read data is registered
// with the ack, and write data takes effect on that same edge. The cycle
// after an ack never acks, so back-to-back requests ack every second cycle.
//
// CNT_W must be 1..32 and SYNC_STAGES must be at least 2.
module usb_dbg_event_monitor #(
  parameter int          CNT_W           = 16,
  parameter logic [31:0] STUCK_LIMIT_DEF = 32'd60000,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        ack_tout_stretched_i,
  input  logic        ack_received_stretched_i,
  input  logic        ack_bad_packet_stretched_i,
  input  logic [3:0]  transact_state_i,
  output logic        irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- bus decode ----------------
  logic       acc;
  logic       wr;
  logic [2:0] idx;
  logic       clr;
  logic       w1c_stuck;
  logic       unused_adr;

  assign acc        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = acc & wb_we_i;
  assign idx        = wb_adr_i[4:2];
  assign clr        = wr && (idx == 3'd0) && wb_dat_i[1];
  assign w1c_stuck  = wr && (idx == 3'd4) && wb_dat_i[4];
  // The byte lane within a word has no meaning for these registers.
  assign unused_adr = ^wb_adr_i[1:0];

  // ---------------- control registers ----------------
  logic        en;
  logic        ie;
  logic [31:0] stuck_limit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en          <= 1'b1;
      ie          <= 1'b0;
      stuck_limit <= STUCK_LIMIT_DEF;
    end else if (wr) begin
      if (idx == 3'd0) begin
        en <= wb_dat_i[0];
        ie <= wb_dat_i[2];
      end
      if (idx == 3'd5) stuck_limit <= wb_dat_i;
    end
  end

  // ---------------- event synchronisers and counters ----------------
  // Index 0 = ACK timeout, 1 = ACK received, 2 = bad packet.
  logic [2:0]             ev_raw;
  logic [SYNC_STAGES-1:0] ev_sync [3];
  logic [2:0]             ev_level;
  logic [2:0]             ev_prev;
  logic [2:0]             ev_edge;
  logic [CNT_W-1:0]       cnt [3];
  logic                   sat;

  assign ev_raw = {ack_bad_packet_stretched_i, ack_received_stretched_i,
                   ack_tout_stretched_i};

  always_comb begin
    ev_level = '0;
    for (int i = 0; i < 3; i++) ev_level[i] = ev_sync[i][SYNC_STAGES-1];
  end

  assign ev_edge = ev_level & ~ev_prev;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 3; i++) begin
        ev_sync[i] <= '0;
        cnt[i]     <= '0;
      end
      ev_prev <= '0;
    end else begin
      ev_prev <= ev_level;
      for (int i = 0; i < 3; i++) begin
        ev_sync[i] <= {ev_sync[i][SYNC_STAGES-2:0], ev_raw[i]};
        // CLR beats a coincident edge. The edge is lost, not deferred.
        if (clr) cnt[i] <= '0;
        else if (en && ev_edge[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  assign sat = (cnt[0] == CNT_MAX) | (cnt[1] == CNT_MAX) | (cnt[2] == CNT_MAX);

  // ---------------- state filter and stuck detection ----------------
  logic [3:0]  st_sync [SYNC_STAGES];
  logic [3:0]  st_prev;
  logic [3:0]  st_filt;
  logic        st_stable;
  logic        st_change;
  logic [31:0] stuck_timer;
  logic        stuck;
  logic        stuck_set;

  // Accept a new state only after two equal consecutive samples. This
  // rejects the skew between bits of a multi-bit crossing.
  assign st_stable = (st_sync[SYNC_STAGES-1] == st_prev);
  assign st_change = st_stable && (st_sync[SYNC_STAGES-1] != st_filt);
  assign stuck_set = (stuck_timer == stuck_limit) && (stuck_limit != 32'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) st_sync[i] <= '0;
      st_prev     <= '0;
      st_filt     <= '0;
      stuck_timer <= '0;
      stuck       <= 1'b0;
    end else begin
      st_sync[0] <= transact_state_i;
      for (int i = 1; i < SYNC_STAGES; i++) st_sync[i] <= st_sync[i-1];
      st_prev <= st_sync[SYNC_STAGES-1];
      if (st_stable) st_filt <= st_sync[SYNC_STAGES-1];

      if (clr || st_change || (st_filt == 4'd0)) stuck_timer <= '0;
      else if (stuck_timer != 32'hFFFF_FFFF)      stuck_timer <= stuck_timer + 32'd1;

      // A set condition wins over a coincident W1C, so a live fault is never
      // acknowledged away unseen. CLR is a full restart and wins over both.
      if (clr)            stuck <= 1'b0;
      else if (stuck_set) stuck <= 1'b1;
      else if (w1c_stuck) stuck <= 1'b0;
    end
  end

  // ---------------- read mux, ack, interrupt ----------------
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = {29'd0, ie, 1'b0, en};
      3'd1:    rd_data = 32'(cnt[0]);
      3'd2:    rd_data = 32'(cnt[1]);
      3'd3:    rd_data = 32'(cnt[2]);
      3'd4:    rd_data = {26'd0, sat, stuck, st_filt};
      3'd5:    rd_data = stuck_limit;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      if (acc) wb_dat_o <= rd_data;
      irq_o <= ie & stuck;
    end
  end

endmodule
